// File: rtl/attn_head_sched_if.sv
// Shared data width and the bus bundle between the attention-head scheduler
// and its environment (upstream token source, two-head datapath, controller).
package attn_head_sched_pkg;
  localparam int att_width = 16;
endpackage

interface attn_head_sched_if;
  import attn_head_sched_pkg::*;

  logic                 start;
  logic                 abort;
  logic                 in_valid;
  logic                 in_ready;
  logic [att_width-1:0] in_data;
  logic [att_width-1:0] in_bias_1;
  logic [att_width-1:0] in_bias_2;
  logic                 head_en;
  logic [att_width-1:0] head_data;
  logic [att_width-1:0] head_bias_1;
  logic [att_width-1:0] head_bias_2;
  logic [att_width-1:0] head_out;
  logic                 out_valid;
  logic [att_width-1:0] out_data;
  logic                 busy;
  logic                 done;

  // The slave side is the scheduler; the master side drives tokens and hosts the datapath.
  modport slave (
    input  start, abort, in_valid, in_data, in_bias_1, in_bias_2, head_out,
    output in_ready, head_en, head_data, head_bias_1, head_bias_2,
           out_valid, out_data, busy, done
  );

  modport master (
    output start, abort, in_valid, in_data, in_bias_1, in_bias_2, head_out,
    input  in_ready, head_en, head_data, head_bias_1, head_bias_2,
           out_valid, out_data, busy, done
  );
endinterface

// File: rtl/attn_head_sched.sv
// Attention-head pass scheduler: feeds N_TOKEN tokens into a fixed-latency
// two-head datapath, tags launches to qualify results, and signals pass completion.
module attn_head_sched
  import attn_head_sched_pkg::*;
#(
  parameter int N_TOKEN  = 4,
  parameter int PIPE_LAT = 5
) (
  input logic              clk,
  input logic              rstn,
  attn_head_sched_if.slave bus
);
  localparam int         W    = att_width;
  localparam logic [7:0] NTok = 8'(N_TOKEN);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_e;

  state_e              state_q, state_d;
  logic [7:0]          tokCnt_q, tokCnt_d;
  logic [7:0]          resCnt_q, resCnt_d;
  logic [PIPE_LAT-1:0] tag_q, tag_d;
  logic                launch_q, launch_d;
  logic [W-1:0]        headData_q, headData_d;
  logic [W-1:0]        headBias1_q, headBias1_d;
  logic [W-1:0]        headBias2_q, headBias2_d;

  logic inReady;
  logic accept;
  logic headEn;
  logic outValid;

  assign inReady  = (state_q == LOAD) && (tokCnt_q < NTok);
  assign accept   = bus.in_valid && inReady;
  assign headEn   = (state_q == LOAD) || (state_q == DRAIN);
  assign outValid = tag_q[PIPE_LAT-1];

  // launch_q travels with head_data, so the tag chain behind it lines up with head_out.
  always_comb begin
    state_d     = state_q;
    tokCnt_d    = tokCnt_q;
    resCnt_d    = resCnt_q;
    tag_d       = tag_q;
    launch_d    = 1'b0;
    headData_d  = '0;
    headBias1_d = '0;
    headBias2_d = '0;

    if (headEn) begin
      tag_d[0] = launch_q;
      for (int i = 1; i < PIPE_LAT; i++) begin
        tag_d[i] = tag_q[i-1];
      end
    end

    if (accept) begin
      launch_d    = 1'b1;
      headData_d  = bus.in_data;
      headBias1_d = bus.in_bias_1;
      headBias2_d = bus.in_bias_2;
      tokCnt_d    = tokCnt_q + 8'd1;
    end

    if (outValid) begin
      resCnt_d = resCnt_q + 8'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d  = LOAD;
          tokCnt_d = '0;
          resCnt_d = '0;
        end
      end
      LOAD: begin
        if (accept && (tokCnt_q == NTok - 8'd1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (outValid && (resCnt_q == NTok - 8'd1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort only bites while tokens may be in flight; everything in the pipe is dropped.
    if (bus.abort && headEn) begin
      state_d     = IDLE;
      tokCnt_d    = '0;
      resCnt_d    = '0;
      tag_d       = '0;
      launch_d    = 1'b0;
      headData_d  = '0;
      headBias1_d = '0;
      headBias2_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      tokCnt_q    <= '0;
      resCnt_q    <= '0;
      tag_q       <= '0;
      launch_q    <= 1'b0;
      headData_q  <= '0;
      headBias1_q <= '0;
      headBias2_q <= '0;
    end else begin
      state_q     <= state_d;
      tokCnt_q    <= tokCnt_d;
      resCnt_q    <= resCnt_d;
      tag_q       <= tag_d;
      launch_q    <= launch_d;
      headData_q  <= headData_d;
      headBias1_q <= headBias1_d;
      headBias2_q <= headBias2_d;
    end
  end

  assign bus.in_ready    = inReady;
  assign bus.head_en     = headEn;
  assign bus.head_data   = headData_q;
  assign bus.head_bias_1 = headBias1_q;
  assign bus.head_bias_2 = headBias2_q;
  assign bus.out_valid   = outValid;
  assign bus.out_data    = outValid ? bus.head_out : '0;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
endmodule

// File: tb/tb_attn_head_sched.sv
// Bench for attn_head_sched: two instances (4/5 and 1/1), a behavioural
// datapath, and a queue-based model predicting every output each cycle.
module tb_attn_head_sched;
  import attn_head_sched_pkg::*;
  localparam int W = att_width;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  attn_head_sched_if ifA ();
  attn_head_sched_if ifB ();

  attn_head_sched #(.N_TOKEN(4), .PIPE_LAT(5)) dutA (.clk(clk), .rstn(rstn), .bus(ifA));
  attn_head_sched #(.N_TOKEN(1), .PIPE_LAT(1)) dutB (.clk(clk), .rstn(rstn), .bus(ifB));

  // Behavioural two-head datapath: result is data plus both biases, fixed latency.
  logic [W-1:0] dpA [5];
  logic [W-1:0] dpB;
  always @(posedge clk) begin
    dpA[0] <= ifA.head_data + ifA.head_bias_1 + ifA.head_bias_2;
    for (int i = 1; i < 5; i++) dpA[i] <= dpA[i-1];
    dpB <= ifB.head_data + ifB.head_bias_1 + ifB.head_bias_2;
  end
  assign ifA.head_out = dpA[4];
  assign ifB.head_out = dpB;

  typedef struct {
    int           cyc;
    logic [W-1:0] val;
  } due_t;

  int testsRun    = 0;
  int testsFailed = 0;
  int cyc         = 0;
  int sel         = 0;
  int nTok        = 4;
  int pLat        = 5;
  int mPhase      = 0;
  int mTok        = 0;
  int mRes        = 0;
  logic [W-1:0] hdExp, hb1Exp, hb2Exp;
  due_t dueQ[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d, dut %0d)", tag, obs, exp, cyc, sel);
    end
  endtask

  // Pass rules applied at each clock edge; results are due pLat cycles after their accept.
  task automatic modelEdge(input bit st, input bit ab, input bit iv, input bit rn,
                           input logic [W-1:0] d, input logic [W-1:0] b1, input logic [W-1:0] b2);
    bit   acc;
    bit   ovNow;
    due_t item;
    cyc++;
    hdExp  = '0;
    hb1Exp = '0;
    hb2Exp = '0;
    if (!rn) begin
      mPhase = 0; mTok = 0; mRes = 0;
      dueQ.delete();
      return;
    end
    acc   = (mPhase == 1) && (mTok < nTok) && iv;
    ovNow = (dueQ.size() > 0) && (dueQ[0].cyc == cyc - 1);
    if (ab && (mPhase == 1 || mPhase == 2)) begin
      mPhase = 0; mTok = 0; mRes = 0;
      dueQ.delete();
      return;
    end
    if (acc) begin
      item.cyc = cyc + pLat;
      item.val = d + b1 + b2;
      dueQ.push_back(item);
      mTok++;
      hdExp = d; hb1Exp = b1; hb2Exp = b2;
    end
    if (ovNow) begin
      void'(dueQ.pop_front());
      mRes++;
    end
    case (mPhase)
      0: if (st && !ab) begin mPhase = 1; mTok = 0; mRes = 0; end
      1: if (acc && mTok == nTok) mPhase = 2;
      2: if (mRes == nTok) mPhase = 3;
      default: mPhase = 0;
    endcase
  endtask

  task automatic checkAll();
    bit           ir, he, ov, bz, dn, ovExp;
    logic [W-1:0] od, hd, hb1, hb2, odExp;
    if (sel == 0) begin
      ir = ifA.in_ready; he = ifA.head_en; ov = ifA.out_valid; bz = ifA.busy; dn = ifA.done;
      od = ifA.out_data; hd = ifA.head_data; hb1 = ifA.head_bias_1; hb2 = ifA.head_bias_2;
    end else begin
      ir = ifB.in_ready; he = ifB.head_en; ov = ifB.out_valid; bz = ifB.busy; dn = ifB.done;
      od = ifB.out_data; hd = ifB.head_data; hb1 = ifB.head_bias_1; hb2 = ifB.head_bias_2;
    end
    ovExp = (dueQ.size() > 0) && (dueQ[0].cyc == cyc);
    odExp = ovExp ? dueQ[0].val : '0;
    checkOutput("in_ready",    32'(ir),  32'(mPhase == 1 && mTok < nTok));
    checkOutput("head_en",     32'(he),  32'(mPhase == 1 || mPhase == 2));
    checkOutput("busy",        32'(bz),  32'(mPhase != 0));
    checkOutput("done",        32'(dn),  32'(mPhase == 3));
    checkOutput("out_valid",   32'(ov),  32'(ovExp));
    checkOutput("out_data",    32'(od),  32'(odExp));
    checkOutput("head_data",   32'(hd),  32'(hdExp));
    checkOutput("head_bias_1", 32'(hb1), 32'(hb1Exp));
    checkOutput("head_bias_2", 32'(hb2), 32'(hb2Exp));
  endtask

  task automatic applyStimulus(input bit st, input bit ab, input bit iv, input bit rn,
                               input int d, input int b1, input int b2);
    rstn          = rn;
    ifA.start     = (sel == 0) && st;
    ifA.abort     = (sel == 0) && ab;
    ifA.in_valid  = (sel == 0) && iv;
    ifB.start     = (sel == 1) && st;
    ifB.abort     = (sel == 1) && ab;
    ifB.in_valid  = (sel == 1) && iv;
    ifA.in_data   = W'(d);  ifB.in_data   = W'(d);
    ifA.in_bias_1 = W'(b1); ifB.in_bias_1 = W'(b1);
    ifA.in_bias_2 = W'(b2); ifB.in_bias_2 = W'(b2);
    @(posedge clk);
    modelEdge(st, ab, iv, rn, W'(d), W'(b1), W'(b2));
    @(negedge clk);
    checkAll();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
  endtask

  task automatic token(input int d, input int b1, input int b2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, d, b1, b2);
  endtask

  task automatic startPass();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
  endtask

  task automatic waitIdle(input string tag);
    for (int k = 0; k < 60 && mPhase != 0; k++) idle(1);
    checkOutput(tag, 32'(sel == 0 ? ifA.busy : ifB.busy), 32'(0));
  endtask

  task automatic randomRun(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0,
                    $urandom_range(0, 9) < 6, $urandom_range(0, 149) != 0,
                    int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                    int'($urandom_range(0, 65535)));
    end
  endtask

  initial begin
    sel = 0; nTok = 4; pLat = 5;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    idle(2);

    // Back-to-back stream of four tokens.
    startPass();
    for (int i = 1; i <= 4; i++) token(i, i + 3, 16 * i);
    waitIdle("b2bIdle");
    idle(2);

    // Gapped input pattern 1,0,0,1,1,0,1.
    startPass();
    begin
      bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
      for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, pat[i], 1'b1, 10 + i, 3, 5);
    end
    waitIdle("gapIdle");

    // Abort in DRAIN once two results have come back.
    startPass();
    for (int i = 0; i < 4; i++) token(40 + i, 1, 2);
    for (int k = 0; k < 30 && !(mPhase == 2 && mRes == 2); k++) idle(1);
    checkOutput("drainBusy", 32'(ifA.busy), 32'(1));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 0);
    idle(10);

    // Start pulses during LOAD and DRAIN are ignored; a later start is a fresh pass.
    startPass();
    token(5, 1, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 6, 1, 1);
    token(7, 1, 1);
    token(8, 1, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    waitIdle("startIgnIdle");
    startPass();
    for (int i = 0; i < 4; i++) token(100 + i, 7, 9);
    waitIdle("freshIdle");

    // Reset pulse after three accepts.
    startPass();
    for (int i = 0; i < 3; i++) token(60 + i, 2, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    idle(10);

    // Start with abort in IDLE, and abort landing in DONE.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 0);
    idle(2);
    startPass();
    for (int i = 0; i < 4; i++) token(80 + i, 1, 0);
    for (int k = 0; k < 30 && mPhase != 3; k++) idle(1);
    checkOutput("doneSeen", 32'(ifA.done), 32'(1));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 0);
    idle(2);

    randomRun(600);

    // Single-token, single-latency instance.
    sel = 1; nTok = 1; pLat = 1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    idle(1);
    startPass();
    token(9, 1, 2);
    idle(4);
    randomRun(300);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
